// File: rtl/issue_unit.sv
// issue_unit -- in-order fetch/decode/dispatch front end.
//   Fetches 64-bit words from a synchronous instruction memory (data is valid
//   the cycle after imem_en_o), decodes them and strobes them into the
//   reservation station, retrying every rejected (full) dispatch until it is
//   accepted.
// Ports:
//   clk_i, rst_i (async, active high), start_i   control
//   imem_en_o, imem_addr_o, imem_data_i           instruction memory
//   unit_o, reg1_o..reg3_o, hasimm_o, imm_o,
//   enable_o, out_i                               RS dispatch port
//   busy_o, halted_o, pc_o, *_cnt_o               status / statistics
module issue_unit #(
    parameter int ADDR_W    = 10,
    parameter int START_PC  = 0,
    parameter int WORD_SIZE = 32,
    parameter int REG_SIZE  = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic                 imem_en_o,
    output logic [ADDR_W-1:0]    imem_addr_o,
    input  logic [63:0]          imem_data_i,
    output logic [2:0]           unit_o,
    output logic [REG_SIZE-1:0]  reg1_o,
    output logic [REG_SIZE-1:0]  reg2_o,
    output logic [REG_SIZE-1:0]  reg3_o,
    output logic                 hasimm_o,
    output logic [WORD_SIZE-1:0] imm_o,
    output logic                 enable_o,
    input  logic                 out_i,
    output logic                 busy_o,
    output logic                 halted_o,
    output logic [ADDR_W-1:0]    pc_o,
    output logic [15:0]          issued_cnt_o,
    output logic [15:0]          stall_cnt_o,
    output logic [15:0]          illegal_cnt_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_RESP, S_HALTED
    } state_e;

    localparam logic [ADDR_W-1:0] START = ADDR_W'(START_PC);
    localparam logic [2:0]        U_HALT = 3'b101;

    state_e state_q, state_d;

    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [15:0]          issued_q, issued_d, stall_q, stall_d, illegal_q, illegal_d;
    logic [2:0]           unit_q, unit_d;
    logic [REG_SIZE-1:0]  reg1_q, reg1_d, reg2_q, reg2_d, reg3_q, reg3_d;
    logic                 hasimm_q, hasimm_d;
    logic [WORD_SIZE-1:0] imm_q, imm_d;

    // Decoded view of the memory word (only meaningful in S_WAIT).
    logic [2:0]         dec_unit;
    logic               dec_illegal;
    logic signed [31:0] dec_imm;

    assign dec_unit    = imem_data_i[63:61];
    assign dec_illegal = (dec_unit[2:1] == 2'b11);
    assign dec_imm     = imem_data_i[31:0];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ---- state register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALTED: if (start_i) state_d = S_FETCH;
            S_FETCH:          state_d = S_WAIT;
            S_WAIT:           state_d = dec_illegal ? S_FETCH : S_ISSUE;
            S_ISSUE:          state_d = (unit_q == U_HALT) ? S_HALTED : S_RESP;
            S_RESP:           state_d = out_i ? S_FETCH : S_ISSUE;
            default:          state_d = S_IDLE;
        endcase
    end

    // ---- outputs decoded from state ----
    // enable is a pure state decode so an async reset drops it at once, and
    // ISSUE is never entered twice in a row, guaranteeing a low gap.
    always_comb begin
        imem_en_o = (state_q == S_FETCH);
        enable_o  = (state_q == S_ISSUE);
        halted_o  = (state_q == S_HALTED);
        busy_o    = (state_q != S_IDLE) && (state_q != S_HALTED);
    end

    // ---- datapath next-state ----
    always_comb begin
        pc_d      = pc_q;
        issued_d  = issued_q;
        stall_d   = stall_q;
        illegal_d = illegal_q;
        unit_d    = unit_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        reg3_d    = reg3_q;
        hasimm_d  = hasimm_q;
        imm_d     = imm_q;
        case (state_q)
            S_IDLE, S_HALTED: if (start_i) begin
                pc_d      = START;
                issued_d  = '0;
                stall_d   = '0;
                illegal_d = '0;
            end
            S_WAIT: begin
                if (dec_illegal) begin
                    // Illegal words are skipped without touching the fields,
                    // so they keep showing the last issued instruction.
                    illegal_d = sat_inc(illegal_q);
                    pc_d      = pc_q + 1'b1;
                end else begin
                    unit_d   = dec_unit;
                    hasimm_d = imem_data_i[60];
                    reg1_d   = REG_SIZE'(imem_data_i[59:54]);
                    reg2_d   = REG_SIZE'(imem_data_i[53:48]);
                    reg3_d   = REG_SIZE'(imem_data_i[47:42]);
                    imm_d    = WORD_SIZE'(dec_imm);
                end
            end
            // Halt is counted at its strobe; the RS never answers it.
            S_ISSUE: if (unit_q == U_HALT) issued_d = sat_inc(issued_q);
            S_RESP: begin
                if (out_i) begin
                    issued_d = sat_inc(issued_q);
                    pc_d     = pc_q + 1'b1;   // wraps modulo 2^ADDR_W
                end else begin
                    stall_d  = sat_inc(stall_q);
                end
            end
            default: ;
        endcase
    end

    // ---- datapath registers ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q      <= START;
            issued_q  <= '0;
            stall_q   <= '0;
            illegal_q <= '0;
            unit_q    <= '0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            reg3_q    <= '0;
            hasimm_q  <= 1'b0;
            imm_q     <= '0;
        end else begin
            pc_q      <= pc_d;
            issued_q  <= issued_d;
            stall_q   <= stall_d;
            illegal_q <= illegal_d;
            unit_q    <= unit_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            reg3_q    <= reg3_d;
            hasimm_q  <= hasimm_d;
            imm_q     <= imm_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign unit_o        = unit_q;
    assign reg1_o        = reg1_q;
    assign reg2_o        = reg2_q;
    assign reg3_o        = reg3_q;
    assign hasimm_o      = hasimm_q;
    assign imm_o         = imm_q;
    assign issued_cnt_o  = issued_q;
    assign stall_cnt_o   = stall_q;
    assign illegal_cnt_o = illegal_q;
endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: a full-size instance plus a 2-bit-address
// instance for PC wrap. A small RS model answers each strobe from a
// reject budget; strobes and fetch addresses are logged on the falling edge.
module tb_issue_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0, start = 1'b0, start_s = 1'b0, out_r = 1'b1, out_s = 1'b1;

    // ---- main instance (ADDR_W=10, START_PC=0) ----
    logic        imem_en, enable, hasimm, busy, halted;
    logic [9:0]  imem_addr, pc;
    logic [63:0] imem_data;
    logic [2:0]  unit;
    logic [5:0]  reg1, reg2, reg3;
    logic [31:0] imm;
    logic [15:0] issued, stall, illegal;

    issue_unit #(.ADDR_W(10), .START_PC(0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .imem_en_o(imem_en), .imem_addr_o(imem_addr), .imem_data_i(imem_data),
        .unit_o(unit), .reg1_o(reg1), .reg2_o(reg2), .reg3_o(reg3),
        .hasimm_o(hasimm), .imm_o(imm), .enable_o(enable), .out_i(out_r),
        .busy_o(busy), .halted_o(halted), .pc_o(pc),
        .issued_cnt_o(issued), .stall_cnt_o(stall), .illegal_cnt_o(illegal));

    // ---- wrap instance (ADDR_W=2, START_PC=3) ----
    logic        imem_en_s, enable_s, hasimm_s, busy_s, halted_s;
    logic [1:0]  imem_addr_s, pc_s;
    logic [63:0] imem_data_s;
    logic [2:0]  unit_s;
    logic [5:0]  reg1_s, reg2_s, reg3_s;
    logic [31:0] imm_s;
    logic [15:0] issued_s, stall_s, illegal_s;

    issue_unit #(.ADDR_W(2), .START_PC(3)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start_s),
        .imem_en_o(imem_en_s), .imem_addr_o(imem_addr_s), .imem_data_i(imem_data_s),
        .unit_o(unit_s), .reg1_o(reg1_s), .reg2_o(reg2_s), .reg3_o(reg3_s),
        .hasimm_o(hasimm_s), .imm_o(imm_s), .enable_o(enable_s), .out_i(out_s),
        .busy_o(busy_s), .halted_o(halted_s), .pc_o(pc_s),
        .issued_cnt_o(issued_s), .stall_cnt_o(stall_s), .illegal_cnt_o(illegal_s));

    // ---- memories ----
    logic [63:0] mem  [0:1023];
    logic [63:0] smem [0:3];
    always @(posedge clk) if (imem_en)   imem_data   <= mem[imem_addr];
    always @(posedge clk) if (imem_en_s) imem_data_s <= smem[imem_addr_s];

    function automatic logic [63:0] enc(input logic [2:0] u, input logic h,
        input logic [5:0] a, input logic [5:0] b, input logic [5:0] c, input logic [31:0] im);
        return {u, h, a, b, c, 10'h0, im};
    endfunction

    // ---- cycle count and RS model / logger ----
    int cyc = 0, st = 0, rej = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          p_n = 0;
    int          p_cyc [16];
    logic [2:0]  p_unit[16];
    logic [5:0]  p_r1[16], p_r2[16], p_r3[16];
    logic        p_hi[16];
    logic [31:0] p_imm[16];
    logic [9:0]  p_pc[16];

    // Strobe seen after edge k is sampled by the RS at edge k+1.
    always @(negedge clk) if (!rst && enable) begin
        if (p_n < 16) begin
            p_cyc[p_n] = cyc - st + 1;
            p_unit[p_n] = unit; p_r1[p_n] = reg1; p_r2[p_n] = reg2; p_r3[p_n] = reg3;
            p_hi[p_n] = hasimm; p_imm[p_n] = imm; p_pc[p_n] = pc;
            p_n = p_n + 1;
        end
        out_r = (rej == 0);
        if (rej > 0) rej = rej - 1;
    end

    int         s_n = 0, f_n = 0;
    logic [2:0] s_unit[8];
    logic [1:0] s_fa[8];
    always @(negedge clk) if (!rst) begin
        if (enable_s  && s_n < 8) begin s_unit[s_n] = unit_s; s_n = s_n + 1; end
        if (imem_en_s && f_n < 8) begin s_fa[f_n] = imem_addr_s; f_n = f_n + 1; end
    end

    int n_vec = 0, n_err = 0;

    task automatic pulse_start();
        p_n = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; st = cyc;
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        n_vec++;
        if (halted !== 1'b1) begin n_err++; $display("FAIL %s halt_timeout: halted=%b want 1", name, halted); end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1; #1;
        n_vec++; if (enable !== 1'b0)  begin n_err++; $display("FAIL rst_enable: got %b want 0", enable); end
        n_vec++; if (imem_en !== 1'b0) begin n_err++; $display("FAIL rst_imem_en: got %b want 0", imem_en); end
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (halted !== 1'b0)  begin n_err++; $display("FAIL rst_halted: got %b want 0", halted); end
        n_vec++; if (pc !== 10'd0)     begin n_err++; $display("FAIL rst_pc: got %0d want 0", pc); end
        n_vec++; if (pc_s !== 2'd3)    begin n_err++; $display("FAIL rst_pc_s: got %0d want 3", pc_s); end
        n_vec++; if ({issued, stall, illegal} !== 48'h0) begin n_err++; $display("FAIL rst_counters: got %h want 0", {issued, stall, illegal}); end
        n_vec++; if ({unit, reg1, reg2, reg3, hasimm, imm} !== 54'h0) begin n_err++; $display("FAIL rst_fields: got %h want 0", {unit, reg1, reg2, reg3, hasimm, imm}); end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        mem[0] = enc(3'b010, 1'b0, 6'd3, 6'd1, 6'd2, 32'd0);
        mem[1] = enc(3'b101, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
        rej = 0; out_r = 1'b1;
        pulse_start();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy); end
        wait_halt("basic");
        n_vec++; if (p_n !== 2) begin n_err++; $display("FAIL basic_npulse: got %0d want 2", p_n); end
        n_vec++; if (p_cyc[0] !== 3 || p_unit[0] !== 3'b010) begin n_err++; $display("FAIL basic_p0: cyc %0d unit %b want 3 010", p_cyc[0], p_unit[0]); end
        n_vec++; if (p_cyc[1] !== 7 || p_unit[1] !== 3'b101) begin n_err++; $display("FAIL basic_p1: cyc %0d unit %b want 7 101", p_cyc[1], p_unit[1]); end
        n_vec++; if ({p_r1[0], p_r2[0], p_r3[0]} !== {6'd3, 6'd1, 6'd2}) begin n_err++; $display("FAIL basic_regs: got %h want %h", {p_r1[0], p_r2[0], p_r3[0]}, {6'd3, 6'd1, 6'd2}); end
        n_vec++; if (issued !== 16'd2) begin n_err++; $display("FAIL basic_issued: got %0d want 2", issued); end
        n_vec++; if (pc !== 10'd1)     begin n_err++; $display("FAIL basic_pc: got %0d want 1", pc); end
        n_vec++; if (busy !== 1'b0)    begin n_err++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_imm();
        mem[0] = enc(3'b000, 1'b1, 6'd2, 6'd5, 6'd0, 32'hFFFF_FFFC);
        mem[1] = enc(3'b101, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
        rej = 0;
        pulse_start();
        wait_halt("imm");
        n_vec++; if (p_unit[0] !== 3'b000) begin n_err++; $display("FAIL imm_unit: got %b want 000", p_unit[0]); end
        n_vec++; if (p_imm[0] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL imm_value: got %h want fffffffc", p_imm[0]); end
        n_vec++; if (p_r2[0] !== 6'd5 || p_hi[0] !== 1'b1) begin n_err++; $display("FAIL imm_reg2_hasimm: got %0d/%b want 5/1", p_r2[0], p_hi[0]); end
    endtask

    task automatic test_retry();
        mem[0] = enc(3'b011, 1'b0, 6'd7, 6'd8, 6'd9, 32'd0);
        mem[1] = enc(3'b101, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
        rej = 3;
        pulse_start();
        wait_halt("retry");
        n_vec++; if (p_n !== 5) begin n_err++; $display("FAIL retry_npulse: got %0d want 5", p_n); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (p_cyc[i] !== 3 + 2 * i || p_unit[i] !== 3'b011 || {p_r1[i], p_r2[i], p_r3[i]} !== {6'd7, 6'd8, 6'd9} || p_pc[i] !== 10'd0) begin
                n_err++; $display("FAIL retry_pulse%0d: cyc %0d unit %b regs %h pc %0d want %0d 011 %h 0", i, p_cyc[i], p_unit[i], {p_r1[i], p_r2[i], p_r3[i]}, p_pc[i], 3 + 2 * i, {6'd7, 6'd8, 6'd9});
            end
        end
        n_vec++; if (p_cyc[4] !== 13 || p_unit[4] !== 3'b101) begin n_err++; $display("FAIL retry_halt: cyc %0d unit %b want 13 101", p_cyc[4], p_unit[4]); end
        n_vec++; if (stall !== 16'd3)  begin n_err++; $display("FAIL retry_stall: got %0d want 3", stall); end
        n_vec++; if (issued !== 16'd2) begin n_err++; $display("FAIL retry_issued: got %0d want 2", issued); end
        n_vec++; if (pc !== 10'd1)     begin n_err++; $display("FAIL retry_pc: got %0d want 1", pc); end
    endtask

    task automatic test_illegal();
        mem[0] = enc(3'b111, 1'b0, 6'd1, 6'd1, 6'd1, 32'd0);
        mem[1] = enc(3'b100, 1'b1, 6'd4, 6'd0, 6'd0, 32'd42);
        mem[2] = enc(3'b101, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
        rej = 0;
        pulse_start();
        wait_halt("illegal");
        n_vec++; if (illegal !== 16'd1) begin n_err++; $display("FAIL illegal_cnt: got %0d want 1", illegal); end
        n_vec++; if (p_n !== 2) begin n_err++; $display("FAIL illegal_npulse: got %0d want 2", p_n); end
        n_vec++; if (p_unit[0] !== 3'b100 || p_imm[0] !== 32'd42 || p_pc[0] !== 10'd1 || p_cyc[0] !== 5) begin
            n_err++; $display("FAIL illegal_mv: unit %b imm %0d pc %0d cyc %0d want 100 42 1 5", p_unit[0], p_imm[0], p_pc[0], p_cyc[0]);
        end
        n_vec++; if (issued !== 16'd2 || pc !== 10'd2) begin n_err++; $display("FAIL illegal_end: issued %0d pc %0d want 2 2", issued, pc); end
    endtask

    task automatic test_wrap();
        smem[3] = enc(3'b010, 1'b0, 6'd1, 6'd2, 6'd3, 32'd0);
        smem[0] = enc(3'b101, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
        s_n = 0; f_n = 0;
        @(negedge clk); start_s = 1'b1;
        @(negedge clk); start_s = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (halted_s) break;
        end
        n_vec++; if (halted_s !== 1'b1) begin n_err++; $display("FAIL wrap_halt_timeout: halted=%b want 1", halted_s); end
        n_vec++; if (f_n !== 2 || s_fa[0] !== 2'd3 || s_fa[1] !== 2'd0) begin n_err++; $display("FAIL wrap_fetch: n %0d a0 %0d a1 %0d want 2 3 0", f_n, s_fa[0], s_fa[1]); end
        n_vec++; if (s_n !== 2 || s_unit[0] !== 3'b010 || s_unit[1] !== 3'b101) begin n_err++; $display("FAIL wrap_units: n %0d %b %b want 2 010 101", s_n, s_unit[0], s_unit[1]); end
        n_vec++; if (pc_s !== 2'd0 || issued_s !== 16'd2) begin n_err++; $display("FAIL wrap_end: pc %0d issued %0d want 0 2", pc_s, issued_s); end
    endtask

    task automatic test_reset_mid();
        int seen;
        mem[0] = enc(3'b010, 1'b0, 6'd3, 6'd1, 6'd2, 32'd0);
        mem[1] = enc(3'b101, 1'b0, 6'd0, 6'd0, 6'd0, 32'd0);
        rej = 1;
        pulse_start();
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(posedge clk); #1;
            if (enable) seen++;
        end
        n_vec++; if (seen !== 2 || stall !== 16'd1) begin n_err++; $display("FAIL rmid_pre: strobes %0d stall %0d want 2 1", seen, stall); end
        rst = 1'b1; #1;
        n_vec++; if (enable !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_drop: enable %b busy %b want 0 0", enable, busy); end
        n_vec++; if ({issued, stall, illegal} !== 48'h0 || pc !== 10'd0) begin n_err++; $display("FAIL rmid_state: cnt %h pc %0d want 0 0", {issued, stall, illegal}, pc); end
        @(negedge clk); rst = 1'b0; rej = 0; out_r = 1'b1;
        pulse_start();
        wait_halt("rmid_restart");
        n_vec++; if (p_n !== 2 || p_cyc[0] !== 3 || p_pc[0] !== 10'd0) begin n_err++; $display("FAIL rmid_restart: n %0d cyc %0d pc %0d want 2 3 0", p_n, p_cyc[0], p_pc[0]); end
        n_vec++; if (issued !== 16'd2 || stall !== 16'd0) begin n_err++; $display("FAIL rmid_counts: issued %0d stall %0d want 2 0", issued, stall); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_imm();
        test_retry();
        test_illegal();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
